// File: rtl/jpeg_stream_feeder.sv
`timescale 1ns/1ps
// jpeg_stream_feeder: packs host bytes MSB-first into 32-bit words and queues them for jpeg_decode; a word is visible the cycle after its 4th byte.
// ByteInReady drops while the word FIFO is full. Define JPEG_FEEDER_STAT_EN to add the ByteCount/WordCount ports.
module jpeg_stream_feeder #(
  parameter int FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic [7:0]  ByteIn,
  input  logic        ByteInValid,
  output logic        ByteInReady,
  output logic [31:0] DataOut,
  output logic        DataOutEnable,
  input  logic        DataOutRead,
  output logic        JpegDecodeStart,
  input  logic        JpegDecodeIdle,
  output logic        Busy,
  output logic        EoiSeen
`ifdef JPEG_FEEDER_STAT_EN
  ,
  output logic [31:0] ByteCount,
  output logic [31:0] WordCount
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_FILL  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]         r_state;
  logic [31:0]        r_mem [0:(1<<FIFO_AW)-1];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]   r_count;
  logic [31:0]        r_pack_word;
  logic [1:0]         r_pack_cnt;
  logic               r_prev_ff;
  logic               r_eoi_seen;

  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic        w_is_eoi;
  logic        w_wr_en;
  logic        w_pop;
  logic        w_start_ok;
  logic [31:0] w_next_word;
  logic [31:0] w_wr_dat;

  // Occupancy never exceeds the depth, so its MSB alone marks full.
  assign w_full      = r_count[FIFO_AW];
  assign w_empty     = (r_count == '0);
  assign ByteInReady = (r_state == S_FILL) && !w_full;
  assign w_accept    = ByteInValid && ByteInReady;
  assign w_is_eoi    = w_accept && r_prev_ff && (ByteIn == 8'hD9);
  assign w_pop       = DataOutRead && !w_empty;
  assign w_start_ok  = (r_state == S_IDLE) && Start;
  assign w_wr_en     = (w_accept && (r_pack_cnt == 2'd3)) ||
                       ((r_state == S_FLUSH) && (r_pack_cnt != 2'd0) && !w_full);
  assign w_wr_dat    = (r_state == S_FLUSH) ? r_pack_word : w_next_word;

  always_comb begin
    w_next_word = r_pack_word;
    case (r_pack_cnt)
      2'd0:    w_next_word[31:24] = ByteIn;
      2'd1:    w_next_word[23:16] = ByteIn;
      2'd2:    w_next_word[15:8]  = ByteIn;
      default: w_next_word[7:0]   = ByteIn;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_eoi_seen <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_state    <= S_START;
            r_eoi_seen <= 1'b0;
          end
        end
        S_START: r_state <= S_FILL;
        S_FILL: begin
          if (w_is_eoi) begin
            r_eoi_seen <= 1'b1;
            r_state    <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if ((r_pack_cnt == 2'd0) || !w_full) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_empty && JpegDecodeIdle) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The pack register is zeroed after every write so a flushed partial word is already padded.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pack_word <= 32'h0;
      r_pack_cnt  <= 2'd0;
      r_prev_ff   <= 1'b0;
    end else if (r_state == S_START) begin
      r_pack_word <= 32'h0;
      r_pack_cnt  <= 2'd0;
      r_prev_ff   <= 1'b0;
    end else if (w_accept) begin
      r_prev_ff   <= (ByteIn == 8'hFF);
      r_pack_word <= (r_pack_cnt == 2'd3) ? 32'h0 : w_next_word;
      r_pack_cnt  <= r_pack_cnt + 2'd1;
    end else if ((r_state == S_FLUSH) && w_wr_en) begin
      r_pack_word <= 32'h0;
      r_pack_cnt  <= 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= w_wr_dat;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign DataOut         = w_empty ? 32'h0 : r_mem[r_rd_ptr];
  assign DataOutEnable   = !w_empty;
  assign JpegDecodeStart = (r_state == S_START);
  assign Busy            = (r_state != S_IDLE);
  assign EoiSeen         = r_eoi_seen;

`ifdef JPEG_FEEDER_STAT_EN
  logic [31:0] r_byte_cnt;
  logic [31:0] r_word_cnt;

  always_ff @(posedge clk) begin
    if (!rst || w_start_ok) begin
      r_byte_cnt <= 32'h0;
      r_word_cnt <= 32'h0;
    end else begin
      if (w_accept) r_byte_cnt <= r_byte_cnt + 32'd1;
      if (w_pop)    r_word_cnt <= r_word_cnt + 32'd1;
    end
  end

  assign ByteCount = r_byte_cnt;
  assign WordCount = r_word_cnt;
`endif

endmodule

// File: tb/tb_jpeg_stream_feeder.sv
`timescale 1ns/1ps
// Directed bench for jpeg_stream_feeder: drives inputs 2ns after posedge, samples at negedge.
module tb_jpeg_stream_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic [7:0]  ByteIn;
  logic        ByteInValid;
  logic        ByteInReady;
  logic [31:0] DataOut;
  logic        DataOutEnable;
  logic        DataOutRead;
  logic        JpegDecodeStart;
  logic        JpegDecodeIdle;
  logic        Busy;
  logic        EoiSeen;
`ifdef JPEG_FEEDER_STAT_EN
  logic [31:0] ByteCount;
  logic [31:0] WordCount;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;
  logic [31:0] got_q [$];

  always #5 clk = ~clk;

  jpeg_stream_feeder #(.FIFO_AW(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .Start           (Start),
    .ByteIn          (ByteIn),
    .ByteInValid     (ByteInValid),
    .ByteInReady     (ByteInReady),
    .DataOut         (DataOut),
    .DataOutEnable   (DataOutEnable),
    .DataOutRead     (DataOutRead),
    .JpegDecodeStart (JpegDecodeStart),
    .JpegDecodeIdle  (JpegDecodeIdle),
    .Busy            (Busy),
    .EoiSeen         (EoiSeen)
`ifdef JPEG_FEEDER_STAT_EN
    ,
    .ByteCount       (ByteCount),
    .WordCount       (WordCount)
`endif
  );

  // Records every word the decoder side pops and every start pulse.
  always @(negedge clk) begin
    if (rst && DataOutEnable && DataOutRead) got_q.push_back(DataOut);
    if (JpegDecodeStart) start_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_start;
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    ByteIn = b;
    ByteInValid = 1'b1;
    for (n = 0; n < 500; n++) begin
      @(negedge clk);
      if (ByteInReady) break;
    end
    n_checks++;
    if (n >= 500) begin
      n_fail++;
      $display("FAIL send_byte_timeout byte=%h ByteInReady=%b required 1", b, ByteInReady);
    end
    tick();
    ByteInValid = 1'b0;
  endtask

  task automatic wait_idle;
    int n;
    for (n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (!Busy) break;
    end
    n_checks++;
    if (n >= 2000) begin
      n_fail++;
      $display("FAIL wait_idle_timeout Busy=%b required 0", Busy);
    end
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    n_checks += 6;
    if (Busy !== 1'b0)            begin n_fail++; $display("FAIL rst_busy got %b exp 0", Busy); end
    if (DataOutEnable !== 1'b0)   begin n_fail++; $display("FAIL rst_dataoutenable got %b exp 0", DataOutEnable); end
    if (DataOut !== 32'h0)        begin n_fail++; $display("FAIL rst_dataout got %h exp 0", DataOut); end
    if (ByteInReady !== 1'b0)     begin n_fail++; $display("FAIL rst_byteinready got %b exp 0", ByteInReady); end
    if (JpegDecodeStart !== 1'b0) begin n_fail++; $display("FAIL rst_start got %b exp 0", JpegDecodeStart); end
    if (EoiSeen !== 1'b0)         begin n_fail++; $display("FAIL rst_eoiseen got %b exp 0", EoiSeen); end
`ifdef JPEG_FEEDER_STAT_EN
    n_checks += 2;
    if (ByteCount !== 32'd0) begin n_fail++; $display("FAIL rst_bytecount got %0d exp 0", ByteCount); end
    if (WordCount !== 32'd0) begin n_fail++; $display("FAIL rst_wordcount got %0d exp 0", WordCount); end
`endif
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    logic [7:0]  bytes [8] = '{8'hFF, 8'hD8, 8'hFF, 8'hE0, 8'h12, 8'h34, 8'hFF, 8'hD9};
    logic [31:0] exp [2]   = '{32'hFFD8FFE0, 32'h1234FFD9};
    logic [31:0] w;
    int s0, base;
    JpegDecodeIdle = 1'b0;
    DataOutRead = 1'b1;
    s0 = start_cnt;
    base = got_q.size();
    do_start();
    foreach (bytes[i]) send_byte(bytes[i]);
    repeat (5) @(negedge clk);
    n_checks += 3;
    if (Busy !== 1'b1)          begin n_fail++; $display("FAIL basic_drain_busy got %b exp 1", Busy); end
    if (EoiSeen !== 1'b1)       begin n_fail++; $display("FAIL basic_eoiseen got %b exp 1", EoiSeen); end
    if (DataOutEnable !== 1'b0) begin n_fail++; $display("FAIL basic_drained got %b exp 0", DataOutEnable); end
    tick();
    JpegDecodeIdle = 1'b1;
    wait_idle();
    n_checks += 2;
    if (start_cnt - s0 != 1)      begin n_fail++; $display("FAIL basic_start_pulses got %0d exp 1", start_cnt - s0); end
    if (got_q.size() - base != 2) begin n_fail++; $display("FAIL basic_word_count got %0d exp 2", got_q.size() - base); end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      w = (base + i < got_q.size()) ? got_q[base + i] : 32'hx;
      if (w !== exp[i]) begin n_fail++; $display("FAIL basic_word%0d got %h exp %h", i, w, exp[i]); end
    end
`ifdef JPEG_FEEDER_STAT_EN
    n_checks += 2;
    if (ByteCount !== 32'd8) begin n_fail++; $display("FAIL stat_bytecount got %0d exp 8", ByteCount); end
    if (WordCount !== 32'd2) begin n_fail++; $display("FAIL stat_wordcount got %0d exp 2", WordCount); end
`endif
  endtask

  task automatic test_pad;
    logic [7:0]  bytes [7] = '{8'hAB, 8'hCD, 8'hFF, 8'h00, 8'hEF, 8'hFF, 8'hD9};
    logic [31:0] exp [2]   = '{32'hABCDFF00, 32'hEFFFD900};
    logic [31:0] w;
    int base;
    DataOutRead = 1'b1;
    base = got_q.size();
    do_start();
    @(negedge clk);
    n_checks++;
    if (EoiSeen !== 1'b0) begin n_fail++; $display("FAIL pad_eoi_cleared got %b exp 0", EoiSeen); end
`ifdef JPEG_FEEDER_STAT_EN
    n_checks += 2;
    if (ByteCount !== 32'd0) begin n_fail++; $display("FAIL stat_byte_clear got %0d exp 0", ByteCount); end
    if (WordCount !== 32'd0) begin n_fail++; $display("FAIL stat_word_clear got %0d exp 0", WordCount); end
`endif
    tick();
    for (int i = 0; i < 4; i++) send_byte(bytes[i]);
    @(negedge clk);
    n_checks += 2;
    if (EoiSeen !== 1'b0)     begin n_fail++; $display("FAIL pad_stuff_not_eoi got %b exp 0", EoiSeen); end
    if (ByteInReady !== 1'b1) begin n_fail++; $display("FAIL pad_still_fill got %b exp 1", ByteInReady); end
    tick();
    for (int i = 4; i < 7; i++) send_byte(bytes[i]);
    wait_idle();
    n_checks += 2;
    if (EoiSeen !== 1'b1)         begin n_fail++; $display("FAIL pad_eoiseen got %b exp 1", EoiSeen); end
    if (got_q.size() - base != 2) begin n_fail++; $display("FAIL pad_word_count got %0d exp 2", got_q.size() - base); end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      w = (base + i < got_q.size()) ? got_q[base + i] : 32'hx;
      if (w !== exp[i]) begin n_fail++; $display("FAIL pad_word%0d got %h exp %h", i, w, exp[i]); end
    end
  endtask

  task automatic test_full;
    logic [31:0] w, e;
    int base;
    DataOutRead = 1'b0;
    base = got_q.size();
    do_start();
    for (int i = 0; i < 64; i++) send_byte(8'(i));
    repeat (3) @(negedge clk);
    n_checks += 4;
    if (ByteInReady !== 1'b0)     begin n_fail++; $display("FAIL full_ready got %b exp 0", ByteInReady); end
    if (DataOutEnable !== 1'b1)   begin n_fail++; $display("FAIL full_enable got %b exp 1", DataOutEnable); end
    if (DataOut !== 32'h00010203) begin n_fail++; $display("FAIL full_head got %h exp 00010203", DataOut); end
    if (got_q.size() != base)     begin n_fail++; $display("FAIL full_no_pop got %0d exp 0", got_q.size() - base); end
    tick();
    DataOutRead = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (ByteInReady !== 1'b1) begin n_fail++; $display("FAIL full_ready_resume got %b exp 1", ByteInReady); end
    tick();
    for (int i = 64; i < 80; i++) send_byte(8'(i));
    send_byte(8'hFF);
    send_byte(8'hD9);
    wait_idle();
    n_checks++;
    if (got_q.size() - base != 21) begin n_fail++; $display("FAIL full_word_count got %0d exp 21", got_q.size() - base); end
    for (int i = 0; i < 21; i++) begin
      e = (i == 20) ? 32'hFFD90000 : {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
      w = (base + i < got_q.size()) ? got_q[base + i] : 32'hx;
      n_checks++;
      if (w !== e) begin n_fail++; $display("FAIL full_word%0d got %h exp %h", i, w, e); end
    end
  endtask

  task automatic test_start_ignored;
    logic [31:0] w;
    int s0, base;
    DataOutRead = 1'b1;
    s0 = start_cnt;
    base = got_q.size();
    do_start();
    send_byte(8'h11);
    send_byte(8'h22);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    repeat (2) @(negedge clk);
    n_checks += 3;
    if (start_cnt - s0 != 1)  begin n_fail++; $display("FAIL ign_start_pulses got %0d exp 1", start_cnt - s0); end
    if (Busy !== 1'b1)        begin n_fail++; $display("FAIL ign_busy got %b exp 1", Busy); end
    if (ByteInReady !== 1'b1) begin n_fail++; $display("FAIL ign_still_fill got %b exp 1", ByteInReady); end
    tick();
    send_byte(8'hFF);
    send_byte(8'hD9);
    wait_idle();
    ByteIn = 8'h55;
    ByteInValid = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (ByteInReady !== 1'b0) begin n_fail++; $display("FAIL ign_idle_ready got %b exp 0", ByteInReady); end
    tick();
    ByteInValid = 1'b0;
    @(negedge clk);
    n_checks += 2;
    if (DataOutEnable !== 1'b0)   begin n_fail++; $display("FAIL ign_idle_nowrite got %b exp 0", DataOutEnable); end
    if (got_q.size() - base != 1) begin n_fail++; $display("FAIL ign_word_count got %0d exp 1", got_q.size() - base); end
    n_checks++;
    w = (base < got_q.size()) ? got_q[base] : 32'hx;
    if (w !== 32'h1122FFD9) begin n_fail++; $display("FAIL ign_word0 got %h exp 1122ffd9", w); end
    tick();
  endtask

  task automatic test_reset_mid;
    logic [7:0]  bytes [8] = '{8'hFF, 8'hD8, 8'hFF, 8'hE0, 8'h12, 8'h34, 8'hFF, 8'hD9};
    logic [31:0] exp [2]   = '{32'hFFD8FFE0, 32'h1234FFD9};
    logic [31:0] w;
    int base;
    DataOutRead = 1'b0;
    do_start();
    for (int i = 0; i < 12; i++) send_byte(8'h40 + 8'(i));
    @(negedge clk);
    n_checks++;
    if (DataOut !== 32'h40414243) begin n_fail++; $display("FAIL mid_head got %h exp 40414243", DataOut); end
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    n_checks += 4;
    if (DataOutEnable !== 1'b0) begin n_fail++; $display("FAIL mid_rst_enable got %b exp 0", DataOutEnable); end
    if (Busy !== 1'b0)          begin n_fail++; $display("FAIL mid_rst_busy got %b exp 0", Busy); end
    if (EoiSeen !== 1'b0)       begin n_fail++; $display("FAIL mid_rst_eoi got %b exp 0", EoiSeen); end
    if (DataOut !== 32'h0)      begin n_fail++; $display("FAIL mid_rst_dataout got %h exp 0", DataOut); end
    tick();
    DataOutRead = 1'b1;
    base = got_q.size();
    do_start();
    foreach (bytes[i]) send_byte(bytes[i]);
    wait_idle();
    n_checks++;
    if (got_q.size() - base != 2) begin n_fail++; $display("FAIL mid_word_count got %0d exp 2", got_q.size() - base); end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      w = (base + i < got_q.size()) ? got_q[base + i] : 32'hx;
      if (w !== exp[i]) begin n_fail++; $display("FAIL mid_word%0d got %h exp %h", i, w, exp[i]); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    Start = 1'b0;
    ByteIn = 8'h00;
    ByteInValid = 1'b0;
    DataOutRead = 1'b0;
    JpegDecodeIdle = 1'b1;
    test_reset();
    test_basic();
    test_pad();
    test_full();
    test_start_ignored();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
